// File: rtl/pipe_stage_elastic_pkg.sv
// Shared constants and types for the elastic pipeline-stage register.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipe_stage_elastic_pkg;

  // Default width of the back-pressure counter.
  localparam int PIPE_CNT_W_DEFAULT = 16;

  // Payload loaded on reset/flush: the bubble (NOP) encoding.
  localparam logic [31:0] PIPE_NOP_PAYLOAD = 32'h0000_0000;

  // Per-stage payload field offsets. Stages pack/unpack against these.
  // Fetch -> decode payload: {flags, pc[15:0], insn[11:0]} packed into 32 bits.
  localparam int IFID_INSN_LSB  = 0;
  localparam int IFID_INSN_W    = 12;
  localparam int IFID_PC_LSB    = IFID_INSN_LSB + IFID_INSN_W;
  localparam int IFID_PC_W      = 16;
  localparam int IFID_FLAGS_LSB = IFID_PC_LSB + IFID_PC_W;
  localparam int IFID_FLAGS_W   = 4;

  // Decode -> execute payload: {flags, rd, imm} packed into 32 bits.
  localparam int IDEX_IMM_LSB   = 0;
  localparam int IDEX_IMM_W     = 20;
  localparam int IDEX_RD_LSB    = IDEX_IMM_LSB + IDEX_IMM_W;
  localparam int IDEX_RD_W      = 5;
  localparam int IDEX_FLAGS_LSB = IDEX_RD_LSB + IDEX_RD_W;
  localparam int IDEX_FLAGS_W   = 7;

  // Occupancy of the two-entry (skid) variant.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // MAIN empty
    ST_ONE   = 2'd1,  // MAIN full, SKID empty
    ST_FULL  = 2'd2   // MAIN and SKID full
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_elastic_pipe_slot.sv
// One payload entry: a valid bit plus WIDTH data bits with load/clear/drop.
// Latency: load/clear/drop take effect on the next clk edge.
// Backpressure: none; the owner decides when to load or drop.
import pipe_stage_elastic_pkg::*;

module pipe_slot #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,     // empty the slot and restore RST_VAL
  input  logic             load,      // capture load_dat, mark valid
  input  logic             drop,      // mark empty, keep data
  input  logic [WIDTH-1:0] load_dat,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  logic             vld_d, vld_q;
  logic [WIDTH-1:0] dat_d, dat_q;

  // Next entry contents: clear beats load, load beats drop.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clear) begin
      vld_d = 1'b0;
      dat_d = RST_VAL;
    end else if (load) begin
      vld_d = 1'b1;
      dat_d = load_dat;
    end else if (drop) begin
      vld_d = 1'b0;
    end
  end

  // Entry register with synchronous reset to the bubble payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= RST_VAL;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld = vld_q;
  assign dat = dat_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with flush and a saturating stall counter (PIPE_SKID_EN adds a skid entry).
// Latency: 1 cycle from accepted input to out_valid; 1 item/cycle while out_ready is high.
// Backpressure: in_ready = !out_valid || out_ready by default; with PIPE_SKID_EN in_ready is a flop, 1 when SKID is empty.
import pipe_stage_elastic_pkg::*;

module pipe_stage_elastic #(
  parameter int               WIDTH   = 32,
  parameter int               CNT_W   = PIPE_CNT_W_DEFAULT,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(PIPE_NOP_PAYLOAD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_count
);

  logic             main_vld;
  logic [WIDTH-1:0] main_dat;
  logic             main_load;
  logic             main_drop;
  logic [WIDTH-1:0] main_load_dat;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid = main_vld;
  assign out_data  = main_dat;
  assign out_xfer  = main_vld && out_ready;

`ifdef PIPE_SKID_EN

  skid_state_e      state_d, state_q;
  logic             in_ready_d, in_ready_q;
  logic             skid_load;
  logic             skid_drop;
  logic             main_from_skid;
  logic             skid_vld;
  logic [WIDTH-1:0] skid_dat;

  assign in_ready      = in_ready_q;
  assign in_xfer       = in_valid && in_ready_q;
  assign main_load_dat = main_from_skid ? skid_dat : in_data;

  // Occupancy FSM: steer accepted data into MAIN or SKID and refill MAIN from SKID.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (in_xfer) begin
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end else if (out_xfer) begin
          main_drop = 1'b1;
          state_d   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_xfer) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_drop      = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Squash: slots clear themselves; the FSM only needs to forget them.
    if (flush) begin
      state_d = ST_EMPTY;
    end
    // Registered ready: next cycle accepts exactly when SKID will be empty.
    in_ready_d = (state_d != ST_FULL);
  end

  // FSM state and registered in_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_slot #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .load     (skid_load),
    .drop     (skid_drop),
    .load_dat (in_data),
    .vld      (skid_vld),
    .dat      (skid_dat)
  );

`else

  // Single entry: room whenever the entry is empty or leaving this cycle.
  assign in_ready      = !main_vld || out_ready;
  assign in_xfer       = in_valid && in_ready;
  assign main_load     = in_xfer;
  assign main_drop     = out_xfer;
  assign main_load_dat = in_data;

`endif

  pipe_slot #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .load     (main_load),
    .drop     (main_drop),
    .load_dat (main_load_dat),
    .vld      (main_vld),
    .dat      (main_dat)
  );

  logic [CNT_W-1:0] stall_count_d, stall_count_q;

  // Back-pressure counter: counts held-but-not-taken cycles, sticks at all-ones, ignores flush.
  always_comb begin
    stall_count_d = stall_count_q;
    if (main_vld && !out_ready && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic against a queue-based reference model.
// Latency: one model step per clock; outputs sampled 1 time unit after the falling edge.
// Backpressure: the model derives acceptance from occupancy and out_ready.
module tb_pipe_stage_elastic;

  localparam int WIDTH   = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] stall_count;

  pipe_stage_elastic #(
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .RST_VAL ('0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .stall_count (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: FIFO of held items, capacity 1 or 2.
  logic [WIDTH-1:0] mq[$];
  int               m_cnt;
  bit               m_known;      // model state defined (after first reset)
  bit               m_data_zero;  // empty after reset/flush: out_data must be RST_VAL

  int n_checks;
  int n_pass;
  int n_fail;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs to the model, advance the model.
  task automatic step(input bit rst, input bit fl, input bit iv,
                      input logic [WIDTH-1:0] id, input bit ordy);
    bit exp_ov;
    bit exp_ir;
    bit in_acc;
    bit out_acc;
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    exp_ov = (mq.size() > 0);
    if (SKID) exp_ir = (mq.size() < 2);
    else      exp_ir = (mq.size() == 0) || ordy;
    if (m_known) begin
      check("out_valid",   WIDTH'(out_valid),   WIDTH'(exp_ov));
      check("in_ready",    WIDTH'(in_ready),    WIDTH'(exp_ir));
      check("stall_count", WIDTH'(stall_count), WIDTH'(m_cnt));
      if (exp_ov)           check("out_data",       out_data, mq[0]);
      else if (m_data_zero) check("out_data_bubble", out_data, '0);
    end
    in_acc  = iv && exp_ir;
    out_acc = exp_ov && ordy;
    if (rst) begin
      mq.delete();
      m_cnt       = 0;
      m_known     = 1'b1;
      m_data_zero = 1'b1;
    end else if (m_known) begin
      if (exp_ov && !ordy && m_cnt < CNT_MAX) m_cnt++;
      if (fl) begin
        mq.delete();
        m_data_zero = 1'b1;
      end else begin
        if (out_acc) void'(mq.pop_front());
        if (in_acc) begin
          mq.push_back(id);
          m_data_zero = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    m_cnt = 0; m_known = 1'b0; m_data_zero = 1'b0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);

    // 1. Reset held two cycles, then idle.
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    check("reset_out_data", out_data, 32'h0);

    // 2. Stream three items with the consumer always ready.
    step(0, 0, 1, 32'h11, 1);
    step(0, 0, 1, 32'h22, 1);
    step(0, 0, 1, 32'h33, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    // 3. Back-pressure while sending two items, then release.
    step(0, 0, 1, 32'hA1, 0);
    step(0, 0, 1, 32'hA2, 0);
    step(0, 0, 1, 32'hA3, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    // 4. Fill, then flush with a competing input that must vanish.
    step(0, 0, 1, 32'hC1, 0);
    step(0, 0, 1, 32'hC2, 0);
    step(0, 1, 1, 32'hBB, 0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    // 5. Long stall to saturate the counter.
    step(0, 0, 1, 32'h55, 0);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) step(0, 0, 0, '0, 0);

    // 6. Reset and flush together mid-stall.
    step(1, 1, 1, 32'h66, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);

    // Randomized traffic with occasional flush and rare reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom(),
           ($urandom_range(0, 2) != 0));
    end
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
